// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, data width and default bit period.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS       = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Read port between the UART transmitter (master) and its upstream FIFO (slave).
interface uart_tx_if;
   import uart_pkg::*;

   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wrapping at each bit boundary.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_reg;

   assign bit_tick = (cnt_reg == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt_reg <= '0;
      end else if (bit_tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a registered-output FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_tx_if.master fifo,
   output logic      tx,
   output logic      busy,
   output logic      tx_done
);

   localparam int unsigned           IDX_W    = $clog2(UART_DATA_BITS);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   uart_state_t               state_reg, state_next;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
   logic [IDX_W-1:0]          idx_reg, idx_next;
   logic                      tx_reg, tx_next;
   logic                      rd_en_reg;
   logic                      busy_reg;
   logic                      baud_clear;
   logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                      parity_reg, parity_next;
`endif

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (baud_clear),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      idx_next    = idx_reg;
      tx_next     = 1'b1;
      baud_clear  = 1'b0;
      tx_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif

      case (state_reg)
         IDLE: begin
            baud_clear = 1'b1;
            if (!fifo.fifo_empty) state_next = FETCH;
         end
         FETCH: begin
            baud_clear = 1'b1;
            state_next = LOAD;
         end
         LOAD: begin
            // FIFO data is valid the cycle after the read strobe
            baud_clear  = 1'b1;
            shift_next  = fifo.fifo_dout;
            idx_next    = '0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo.fifo_dout;
`endif
            state_next  = START;
         end
         START: begin
            if (bit_tick) state_next = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
               idx_next   = idx_reg + 1'b1;
               if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) state_next = STOP;
         end
`endif
         STOP: begin
            tx_done = bit_tick;
            if (bit_tick) state_next = fifo.fifo_empty ? IDLE : FETCH;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Line level is registered from the state being entered, so tx is glitch-free
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         idx_reg    <= '0;
         tx_reg     <= 1'b1;
         rd_en_reg  <= 1'b0;
         busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         idx_reg    <= idx_next;
         tx_reg     <= tx_next;
         rd_en_reg  <= (state_next == FETCH);
         busy_reg   <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   assign fifo.fifo_rd_en = rd_en_reg;
   assign tx              = tx_reg;
   assign busy            = busy_reg;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have a single clock and a synchronous, active-low reset, with ports as follows.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_dout  input  8  upstream FIFO read data, registered in the FIFO and valid one clk after the read strobe.
- fifo_rd_en  output  1  one-cycle read strobe to the upstream FIFO.
- tx  output  1  serial line, idle high.
- busy  output  1  high from leaving IDLE until the frame's stop bit completes.
- tx_done  output  1  one-cycle pulse on the last clk of each stop bit.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-004 IDLE SHALL go to FETCH when fifo_empty=0, and otherwise stay in IDLE.
REQ-005 fifo_rd_en SHALL be registered and high only for the single cycle spent in FETCH; FETCH SHALL always go to LOAD.
REQ-006 LOAD SHALL capture fifo_dout into an 8-bit shift register, reset the baud counter and go to START.
- Timing: fifo_empty falls in cycle 0, FETCH is cycle 1, LOAD is cycle 2, and tx is low from cycle 3.
REQ-007 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-008 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles.
- A 3-bit index counts 0..7.
- The shift register shifts right at each bit boundary.
REQ-009 Baud counter behaviour:
- Width $clog2(CLKS_PER_BIT).
- Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Never exceeds CLKS_PER_BIT-1.
REQ-010 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles and pulse tx_done in its final cycle. Next state from STOP:
- FETCH if fifo_empty=0 (back-to-back frames with no idle gap).
- IDLE otherwise.
REQ-011 A frame SHALL last exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from the tx falling edge to the end of the stop bit.
REQ-012 fifo_empty SHALL be ignored in every state other than IDLE and the final STOP cycle; a FIFO that fills or drains mid-frame SHALL not alter the frame in progress.
REQ-013 The block SHALL issue exactly one fifo_rd_en per frame and never assert it while in START, DATA, PARITY or STOP.
REQ-014 busy SHALL be low only in IDLE.

Reset
REQ-015 While rst_n=0 at a clk edge the following SHALL hold:
- state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0.
- Baud counter, bit index and shift register are cleared.
REQ-016 A reset mid-frame SHALL abort the frame: tx=1 on the next cycle and no partial bits resume afterwards.
REQ-017 After reset deasserts, the first FETCH SHALL occur no earlier than one cycle after rst_n=1 is sampled.

Configuration
REQ-018 When macro UART_TX_PARITY_EN is defined, the PARITY state SHALL be compiled in.
- It is entered after data bit 7.
- It drives tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then goes to STOP.
REQ-019 When UART_TX_PARITY_EN is undefined, PARITY logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-020 Shared package uart_pkg SHALL hold the following; uart_tx SHALL import it.
- The FSM state encoding constants.
- UART_DATA_BITS=8.
- The default CLKS_PER_BIT=868.
REQ-021 The baud counter SHALL be a sub-module uart_baud_cnt with the following interface; uart_tx SHALL instantiate it once.
- Inputs: clk, rst_n, clear.
- Output: bit_tick, high when the count equals CLKS_PER_BIT-1.

Verification (bench CLKS_PER_BIT=4)
REQ-022 Single byte: FIFO holds 0xA5 and fifo_empty falls.
- fifo_rd_en is high in cycle 1 only; tx falls at cycle 3.
- Line sequence: 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
- tx_done pulses once; busy is low afterwards.
REQ-023 Back-to-back: FIFO holds 0x00 then 0xFF.
- The second fifo_rd_en occurs the cycle after tx_done.
- Only the 2 FETCH/LOAD cycles of tx=1 separate the frames; 2 tx_done pulses in total.
REQ-024 Empty FIFO held for 200 cycles: fifo_rd_en stays 0, tx stays 1, busy stays 0.
REQ-025 Reset mid-frame: rst_n=0 for 1 cycle during data bit 3 of 0x3C.
- Next cycle: tx=1, busy=0, no tx_done.
- The next queued byte then transmits as a complete frame.
REQ-026 With UART_TX_PARITY_EN, byte 0x07 gives a parity bit of 1 and a 44-cycle frame; byte 0x03 gives parity 0.
